// File: rtl/via_pkg.sv
// Shared VIA register map, LCD pin positions and the LCD sequencer state encoding.
// Imported by the sequencer and its cycle timer.
package via_pkg;

  typedef enum logic [3:0] {
    ORB_IRB = 4'd0,
    ORA_IRA = 4'd1,
    DDRB    = 4'd2,
    DDRA    = 4'd3
  } via_reg_e;

  localparam int LCD_E_BIT  = 7;
  localparam int LCD_RW_BIT = 6;
  localparam int LCD_RS_BIT = 5;

  localparam logic [7:0] DDRB_INIT = 8'hFF;
  localparam logic [7:0] DDRA_INIT = 8'hE0;
  localparam logic [7:0] ORA_INIT  = 8'h00;

  typedef logic [3:0] seq_state_t;

  localparam seq_state_t ST_INIT_DDRB = 4'd0;
  localparam seq_state_t ST_INIT_DDRA = 4'd1;
  localparam seq_state_t ST_INIT_ORA  = 4'd2;
  localparam seq_state_t ST_IDLE      = 4'd3;
  localparam seq_state_t ST_SET_DATA  = 4'd4;
  localparam seq_state_t ST_SET_CTRL  = 4'd5;
  localparam seq_state_t ST_E_RISE    = 4'd6;
  localparam seq_state_t ST_E_HOLD    = 4'd7;
  localparam seq_state_t ST_E_FALL    = 4'd8;
  localparam seq_state_t ST_EXEC_WAIT = 4'd9;

  // Port A image for the LCD control lines; RW is always a write.
  function automatic logic [7:0] lcd_ctrl(input logic rs, input logic e);
    logic [7:0] v;
    v             = 8'h00;
    v[LCD_E_BIT]  = e;
    v[LCD_RW_BIT] = 1'b0;
    v[LCD_RS_BIT] = rs;
    return v;
  endfunction

  // Clear display and return home need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02));
  endfunction

endpackage

// File: rtl/via_lcd_sequencer_cycle_timer.sv
// Loadable down-counter that flags the last cycle of a timed interval.
// Counting stops at 1 so the value can never wrap.
module cycle_timer
  import via_pkg::*;
#(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               dec,
  output logic               expire
);

  localparam logic [TIMER_W-1:0] ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

  logic [TIMER_W-1:0] count_r;

  // Counter register: load wins over decrement, decrement only above one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {TIMER_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r > ONE)) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == ONE);

endmodule

// File: rtl/via_lcd_sequencer.sv
// Drives an HD44780-style LCD through the VIA register port: port setup after
// reset, then each accepted (rs, byte) command becomes timed ORB/ORA writes.
module via_lcd_sequencer
  import via_pkg::*;
#(
  parameter int E_PULSE_CYCLES    = 4,
  parameter int EXEC_CYCLES       = 40,
  parameter int CLEAR_EXEC_CYCLES = 1600,
  parameter int TIMER_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       busy,
  output logic       via_chip_en,
  output logic [3:0] via_register_select,
  output logic [7:0] via_data
);

  localparam logic [TIMER_W-1:0] E_LOAD     = TIMER_W'(E_PULSE_CYCLES);
  localparam logic [TIMER_W-1:0] EXEC_LOAD  = TIMER_W'(EXEC_CYCLES);
  localparam logic [TIMER_W-1:0] CLEAR_LOAD = TIMER_W'(CLEAR_EXEC_CYCLES);

  seq_state_t         state_r;
  logic               rs_r;
  logic [7:0]         data_r;
  logic               timer_load_s;
  logic [TIMER_W-1:0] timer_value_s;
  logic               timer_dec_s;
  logic               timer_expire_s;

  // Timer control derived from the current state.
  always_comb begin
    timer_load_s  = 1'b0;
    timer_value_s = {TIMER_W{1'b0}};
    timer_dec_s   = 1'b0;
    case (state_r)
      ST_E_RISE: begin
        timer_load_s  = 1'b1;
        timer_value_s = E_LOAD;
      end
      ST_E_FALL: begin
        timer_load_s  = 1'b1;
        timer_value_s = is_slow_cmd(rs_r, data_r) ? CLEAR_LOAD : EXEC_LOAD;
      end
      ST_E_HOLD, ST_EXEC_WAIT: begin
        timer_dec_s = 1'b1;
      end
      default: begin
        timer_load_s = 1'b0;
      end
    endcase
  end

  cycle_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load_s),
    .load_value(timer_value_s),
    .dec       (timer_dec_s),
    .expire    (timer_expire_s)
  );

  // Sequencer FSM; every output is a register, strobe defaults low each cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r             <= ST_INIT_DDRB;
      rs_r                <= 1'b0;
      data_r              <= 8'h00;
      cmd_ready           <= 1'b0;
      busy                <= 1'b1;
      via_chip_en         <= 1'b0;
      via_register_select <= 4'd0;
      via_data            <= 8'h00;
    end else begin
      via_chip_en <= 1'b0;
      case (state_r)
        ST_INIT_DDRB: begin
          via_chip_en         <= 1'b1;
          via_register_select <= DDRB;
          via_data            <= DDRB_INIT;
          state_r             <= ST_INIT_DDRA;
        end
        ST_INIT_DDRA: begin
          via_chip_en         <= 1'b1;
          via_register_select <= DDRA;
          via_data            <= DDRA_INIT;
          state_r             <= ST_INIT_ORA;
        end
        ST_INIT_ORA: begin
          via_chip_en         <= 1'b1;
          via_register_select <= ORA_IRA;
          via_data            <= ORA_INIT;
          state_r             <= ST_IDLE;
        end
        ST_IDLE: begin
          // cmd_ready is the registered copy, so there is no path from cmd_valid.
          if (cmd_valid && cmd_ready) begin
            rs_r      <= cmd_rs;
            data_r    <= cmd_data;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ST_SET_DATA;
          end else begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        ST_SET_DATA: begin
          via_chip_en         <= 1'b1;
          via_register_select <= ORB_IRB;
          via_data            <= data_r;
          state_r             <= ST_SET_CTRL;
        end
        ST_SET_CTRL: begin
          via_chip_en         <= 1'b1;
          via_register_select <= ORA_IRA;
          via_data            <= lcd_ctrl(rs_r, 1'b0);
          state_r             <= ST_E_RISE;
        end
        ST_E_RISE: begin
          via_chip_en         <= 1'b1;
          via_register_select <= ORA_IRA;
          via_data            <= lcd_ctrl(rs_r, 1'b1);
          state_r             <= ST_E_HOLD;
        end
        ST_E_HOLD: begin
          if (timer_expire_s) begin
            state_r <= ST_E_FALL;
          end
        end
        ST_E_FALL: begin
          via_chip_en         <= 1'b1;
          via_register_select <= ORA_IRA;
          via_data            <= lcd_ctrl(rs_r, 1'b0);
          state_r             <= ST_EXEC_WAIT;
        end
        ST_EXEC_WAIT: begin
          if (timer_expire_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          state_r   <= ST_INIT_DDRB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_via_lcd_sequencer.sv
// Scoreboard bench: two sequencers (default timing and minimum timing) share one
// reset; expected VIA strobes and ready timing are predicted from each accepted command.
`timescale 1ns/1ps
module tb_via_lcd_sequencer;

  typedef struct packed {
    logic [31:0] t;
    logic [3:0]  sel;
    logic [7:0]  dat;
  } exp_t;

  localparam int LIMIT = 2500;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cyc = 32'd0;
  int          n_cmp = 0;
  int          n_mis = 0;
  logic        end_req = 1'b0;
  logic        done1 = 1'b0;

  logic       v0, rs0, rdy0, busy0, en0;
  logic [7:0] d0, dat0;
  logic [3:0] sel0;
  logic       v1, rs1, rdy1, busy1, en1;
  logic [7:0] d1, dat1;
  logic [3:0] sel1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  via_lcd_sequencer u_dut0 (
    .clk(clk), .reset(reset), .cmd_valid(v0), .cmd_rs(rs0), .cmd_data(d0),
    .cmd_ready(rdy0), .busy(busy0), .via_chip_en(en0),
    .via_register_select(sel0), .via_data(dat0)
  );

  via_lcd_sequencer #(
    .E_PULSE_CYCLES(1), .EXEC_CYCLES(1), .CLEAR_EXEC_CYCLES(3), .TIMER_W(16)
  ) u_dut1 (
    .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_rs(rs1), .cmd_data(d1),
    .cmd_ready(rdy1), .busy(busy1), .via_chip_en(en1),
    .via_register_select(sel1), .via_data(dat1)
  );

  logic       m_v [2];
  logic       m_rs [2];
  logic [7:0] m_d [2];
  logic       m_rdy [2];
  logic       m_busy [2];
  logic       m_en [2];
  logic [3:0] m_sel [2];
  logic [7:0] m_dat [2];

  assign m_v[0] = v0;       assign m_v[1] = v1;
  assign m_rs[0] = rs0;     assign m_rs[1] = rs1;
  assign m_d[0] = d0;       assign m_d[1] = d1;
  assign m_rdy[0] = rdy0;   assign m_rdy[1] = rdy1;
  assign m_busy[0] = busy0; assign m_busy[1] = busy1;
  assign m_en[0] = en0;     assign m_en[1] = en1;
  assign m_sel[0] = sel0;   assign m_sel[1] = sel1;
  assign m_dat[0] = dat0;   assign m_dat[1] = dat1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @cycle %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_mon
    localparam int EP = (g == 0) ? 4 : 1;
    localparam int EX = (g == 0) ? 40 : 1;
    localparam int CX = (g == 0) ? 1600 : 3;

    exp_t        q[$];
    logic [31:0] ready_due = 32'hFFFF_FFFF;
    logic        rst_seen = 1'b0;
    logic        ready_prev = 1'b0;
    logic        hs_prev = 1'b0;
    logic        fin = 1'b0;
    int          e_cnt = 0;
    logic [7:0]  last_dat = 8'h00;
    logic [7:0]  port_a, port_b;

    // VIA register model: latches ORB/ORA on the cycle chip_en is high.
    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        port_a <= 8'h00;
        port_b <= 8'h00;
      end else if (m_en[g]) begin
        if (m_sel[g] == 4'd0) port_b <= m_dat[g];
        else if (m_sel[g] == 4'd1) port_a <= m_dat[g];
      end
    end

    // Monitor: compares strobes, ready timing and E width against the predictions.
    always @(negedge clk) begin
      exp_t        e;
      logic [31:0] h;
      int          w;
      logic        hs;
      if (!reset) begin
        if (!rst_seen)
          chk("reset_outputs", {m_en[g], m_sel[g], m_dat[g], m_rdy[g], m_busy[g]},
              {1'b0, 4'd0, 8'h00, 1'b0, 1'b1});
        rst_seen   = 1'b1;
        q.delete();
        ready_due  = 32'hFFFF_FFFF;
        ready_prev = 1'b0;
        hs_prev    = 1'b0;
        e_cnt      = 0;
      end else begin
        if (rst_seen) begin
          q.push_back(exp_t'{cyc + 32'd1, 4'd2, 8'hFF});
          q.push_back(exp_t'{cyc + 32'd2, 4'd3, 8'hE0});
          q.push_back(exp_t'{cyc + 32'd3, 4'd1, 8'h00});
          ready_due = cyc + 32'd4;
          rst_seen  = 1'b0;
        end
        if (m_en[g]) begin
          chk("strobe_expected", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("strobe_cycle_sel_data_busy", {cyc, m_sel[g], m_dat[g], m_busy[g]},
                {e.t, e.sel, e.dat, 1'b1});
          end
        end else if (q.size() != 0 && q[0].t <= cyc) begin
          chk("strobe_present", 64'(m_en[g]), 64'd1);
          void'(q.pop_front());
        end
        if (cyc == ready_due)
          chk("ready_on_time", {m_rdy[g], m_busy[g]}, {1'b1, 1'b0});
        if (m_rdy[g] && !ready_prev)
          chk("ready_rise_cycle", 64'(cyc), 64'(ready_due));
        if (!m_rdy[g] && ready_prev)
          chk("ready_drop_after_accept", 64'(hs_prev), 64'd1);
        if (port_a[7]) begin
          e_cnt++;
        end else if (e_cnt != 0) begin
          chk("e_high_cycles", 64'(e_cnt), 64'(EP + 1));
          chk("port_b_at_e_fall", 64'(port_b), 64'(last_dat));
          e_cnt = 0;
        end
        hs = m_v[g] && m_rdy[g];
        if (hs) begin
          h = cyc + 32'd1;
          q.push_back(exp_t'{h + 32'd1, 4'd0, m_d[g]});
          q.push_back(exp_t'{h + 32'd2, 4'd1, {2'b00, m_rs[g], 5'b00000}});
          q.push_back(exp_t'{h + 32'd3, 4'd1, {2'b10, m_rs[g], 5'b00000}});
          q.push_back(exp_t'{h + 32'(4 + EP), 4'd1, {2'b00, m_rs[g], 5'b00000}});
          w = (!m_rs[g] && (m_d[g] == 8'h01 || m_d[g] == 8'h02)) ? CX : EX;
          ready_due = h + 32'(5 + EP + w);
          last_dat  = m_d[g];
        end
        hs_prev    = hs;
        ready_prev = m_rdy[g];
        if (end_req && !fin) begin
          chk("queue_drained", 64'(q.size()), 64'd0);
          chk("idle_at_end", {m_rdy[g], m_busy[g]}, {1'b1, 1'b0});
          fin = 1'b1;
        end
      end
    end
  end

  task automatic wait_hs0();
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (rdy0 && v0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("cmd_ready_within_budget", 64'(rdy0), 64'd1);
  endtask

  task automatic send0(input logic rs, input logic [7:0] d);
    v0  = 1'b1;
    rs0 = rs;
    d0  = d;
    wait_hs0();
    v0  = 1'b0;
    rs0 = 1'($urandom);
    d0  = 8'($urandom);
  endtask

  // Fast instance: cmd_valid held high with data changing every cycle.
  initial begin
    v1 = 1'b0; rs1 = 1'b0; d1 = 8'h00;
    wait (reset === 1'b1);
    @(posedge clk);
    #1;
    v1 = 1'b1;
    for (int i = 0; i < 160; i++) begin
      rs1 = 1'($urandom_range(0, 1));
      d1  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    v1    = 1'b0;
    done1 = 1'b1;
  end

  // Default-timing instance: directed bytes, continuous valid, random bytes, mid-pulse reset.
  initial begin
    logic       r;
    logic [7:0] d;
    reset = 1'b0;
    v0 = 1'b0; rs0 = 1'b0; d0 = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    send0(1'b1, 8'h41);
    send0(1'b0, 8'h01);
    send0(1'b0, 8'h38);
    send0(1'b0, 8'h02);
    v0 = 1'b1; rs0 = 1'b1; d0 = 8'h48;
    wait_hs0();
    d0 = 8'h49;
    wait_hs0();
    v0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (i == 5) begin
        r = 1'b0;
        d = 8'h02;
      end else if (d == 8'h01 || d == 8'h02) begin
        r = 1'b1;
      end
      send0(r, d);
    end
    wait (done1);
    v0 = 1'b1; rs0 = 1'b0; d0 = 8'h0C;
    wait_hs0();
    v0 = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    send0(1'b1, 8'h5A);
    for (int i = 0; i < LIMIT && !rdy0; i++) @(negedge clk);
    @(posedge clk);
    #1 end_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
